// File: rtl/cordic_pkg.sv
// Shared constants and tag type for the CORDIC rotation arbiter slice.
// Latency: n/a (package only).
// Backpressure: n/a.
package cordic_pkg;

    // 0x10000 angle units make one full turn (2*pi).
    localparam int CORDIC_ANGLE_FULL  = 32'h0001_0000;
    // Default pipeline depth of the shared rotation core.
    localparam int CORDIC_ROT_LATENCY = 17;
    // Tag id field is sized for the largest supported requester count (8).
    localparam int CORDIC_ID_MAX_W    = 3;

    typedef struct packed {
        logic                       valid;
        logic [CORDIC_ID_MAX_W-1:0] id;
    } cordic_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller gates the grant and advances ptr.
//
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index with highest priority this cycle
//   grant - one-hot winner, or all zero when no request is asserted
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Walk the requesters starting at ptr, wrapping modulo NUM_REQ.
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_rotation_arbiter.sv
// Shares one pipelined CORDIC rotation core among NUM_REQ requesters with round-robin issue.
// Latency: CORE_LATENCY+2 cycles from handshake to rsp_valid; one issue per cycle.
// Backpressure: pause blocks new grants only; responses have none and must be accepted.
//
// Ports:
//   clk, nreset (synchronous, active-low), pause
//   req_valid/req_ready, req_x/req_y/req_angle (packed, requester k in slice k)
//   core_enable, core_x/core_y/core_angle to the core; core_x_res/core_y_res from it
//   rsp_valid (one-hot), rsp_x/rsp_y/rsp_id shared result bus, busy
// Optional feature (macro CORDIC_ARB_STATS_EN): stats_clear input and
//   grant_count output with one saturating 16-bit grant counter per requester.
module cordic_rotation_arbiter
    import cordic_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int ANGLE_WIDTH  = 20,
    parameter int CORE_LATENCY = CORDIC_ROT_LATENCY,
    parameter int ID_WIDTH     = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           nreset,
    input  logic                           pause,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_x,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_y,
    input  logic [NUM_REQ*ANGLE_WIDTH-1:0] req_angle,
    output logic                           core_enable,
    output logic [DATA_WIDTH-1:0]          core_x,
    output logic [DATA_WIDTH-1:0]          core_y,
    output logic [ANGLE_WIDTH-1:0]         core_angle,
    input  logic [DATA_WIDTH-1:0]          core_x_res,
    input  logic [DATA_WIDTH-1:0]          core_y_res,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_x,
    output logic [DATA_WIDTH-1:0]          rsp_y,
    output logic [ID_WIDTH-1:0]            rsp_id,
`ifdef CORDIC_ARB_STATS_EN
    input  logic                           stats_clear,
    output logic [NUM_REQ*16-1:0]          grant_count,
`endif
    output logic                           busy
);

    logic [ID_WIDTH-1:0]    ptr;
    logic [ID_WIDTH-1:0]    ptr_nxt;
    logic [NUM_REQ-1:0]     grant;
    logic                   hs;
    logic [ID_WIDTH-1:0]    win_id;
    logic [DATA_WIDTH-1:0]  win_x;
    logic [DATA_WIDTH-1:0]  win_y;
    logic [ANGLE_WIDTH-1:0] win_angle;

    // issue_tag travels alongside core_x/y/angle; tag_sr then tracks the core pipeline.
    cordic_tag_t issue_tag;
    cordic_tag_t tag_sr [CORE_LATENCY];
    cordic_tag_t exit_tag;
    logic        tags_ahead;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    assign req_ready = (nreset && !pause) ? grant : '0;
    assign hs        = |(req_valid & req_ready);

    always_comb begin
        win_id    = '0;
        win_x     = '0;
        win_y     = '0;
        win_angle = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ready[k]) begin
                win_id    = ID_WIDTH'(k);
                win_x     = req_x[k*DATA_WIDTH +: DATA_WIDTH];
                win_y     = req_y[k*DATA_WIDTH +: DATA_WIDTH];
                win_angle = req_angle[k*ANGLE_WIDTH +: ANGLE_WIDTH];
            end
        end
    end

    assign ptr_nxt  = (win_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
    assign exit_tag = tag_sr[CORE_LATENCY-1];

    // Any valid tag that will still be inside the pipeline next cycle keeps the core on.
    always_comb begin
        tags_ahead = issue_tag.valid;
        for (int i = 0; i < CORE_LATENCY - 1; i++) begin
            tags_ahead = tags_ahead | tag_sr[i].valid;
        end
    end

    assign busy = core_enable | tags_ahead | exit_tag.valid;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            ptr         <= '0;
            core_enable <= 1'b0;
            core_x      <= '0;
            core_y      <= '0;
            core_angle  <= '0;
            issue_tag   <= '0;
            for (int i = 0; i < CORE_LATENCY; i++) begin
                tag_sr[i] <= '0;
            end
            rsp_valid   <= '0;
            rsp_x       <= '0;
            rsp_y       <= '0;
            rsp_id      <= '0;
        end else begin
            if (hs) begin
                ptr <= ptr_nxt;
            end
            core_x      <= hs ? win_x     : '0;
            core_y      <= hs ? win_y     : '0;
            core_angle  <= hs ? win_angle : '0;
            issue_tag   <= hs ? '{valid: 1'b1, id: CORDIC_ID_MAX_W'(win_id)} : '0;
            tag_sr[0]   <= issue_tag;
            for (int i = 1; i < CORE_LATENCY; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
            core_enable <= hs | tags_ahead;
            rsp_valid   <= exit_tag.valid ? (NUM_REQ'(1) << exit_tag.id) : '0;
            if (exit_tag.valid) begin
                rsp_x  <= core_x_res;
                rsp_y  <= core_y_res;
                rsp_id <= exit_tag.id[ID_WIDTH-1:0];
            end
        end
    end

`ifdef CORDIC_ARB_STATS_EN
    logic [15:0] cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_REQ; k++) begin
            // Clear wins over a same-cycle increment; counters stick at 0xFFFF.
            if (!nreset || stats_clear) begin
                cnt[k] <= '0;
            end else if (req_valid[k] && req_ready[k] && cnt[k] != 16'hFFFF) begin
                cnt[k] <= cnt[k] + 16'd1;
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            grant_count[k*16 +: 16] = cnt[k];
        end
    end
`endif

endmodule

// File: tb/tb_cordic_rotation_arbiter.sv
module tb_cordic_rotation_arbiter;
    import cordic_pkg::*;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 20;
    localparam int L  = CORDIC_ROT_LATENCY;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            nreset = 1'b0;
    logic            pause = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_x = '0;
    logic [N*DW-1:0] req_y = '0;
    logic [N*AW-1:0] req_angle = '0;
    logic            core_enable;
    logic [DW-1:0]   core_x, core_y, core_x_res, core_y_res;
    logic [AW-1:0]   core_angle;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_x, rsp_y;
    logic [IW-1:0]   rsp_id;
    logic            busy;
`ifdef CORDIC_ARB_STATS_EN
    logic            stats_clear = 1'b0;
    logic [N*16-1:0] grant_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cordic_rotation_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .CORE_LATENCY(L)
    ) dut (
        .clk(clk), .nreset(nreset), .pause(pause),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_angle(req_angle),
        .core_enable(core_enable), .core_x(core_x), .core_y(core_y), .core_angle(core_angle),
        .core_x_res(core_x_res), .core_y_res(core_y_res),
        .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_id(rsp_id),
`ifdef CORDIC_ARB_STATS_EN
        .stats_clear(stats_clear), .grant_count(grant_count),
`endif
        .busy(busy)
    );

    // Stand-in rotation core: L-cycle delay line with an easy-to-predict transform
    // (x_res = ~x, y_res = y + angle[15:0]).
    logic [DW-1:0] px [L];
    logic [DW-1:0] py [L];
    logic [AW-1:0] pa [L];
    logic [AW-1:0] pa_last;

    always @(posedge clk) begin
        px[0] <= core_x;
        py[0] <= core_y;
        pa[0] <= core_angle;
        for (int i = 1; i < L; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
            pa[i] <= pa[i-1];
        end
    end

    assign pa_last    = pa[L-1];
    assign core_x_res = ~px[L-1];
    assign core_y_res = py[L-1] + pa_last[15:0];

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Requester k: x = 0x1000+k, y = 0x100*k, angle = 0x100*k.
    task automatic set_default_data();
        for (int k = 0; k < N; k++) begin
            req_x[k*DW +: DW]     = 16'h1000 + 16'(k);
            req_y[k*DW +: DW]     = 16'h0100 * 16'(k);
            req_angle[k*AW +: AW] = 20'h00100 * 20'(k);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset    = 1'b0;
        req_valid = '0;
        pause     = 1'b0;
        @(negedge clk);
        nreset    = 1'b1;
    endtask

    task automatic test_reset();
        nreset    = 1'b0;
        req_valid = '1;
        repeat (3) begin
            @(negedge clk);
            #1;
            tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
            tests++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL reset_rsp_valid got=%b want=0000", rsp_valid); end
            tests++; if (core_enable !== 1'b0) begin fails++; $display("FAIL reset_core_enable got=%b want=0", core_enable); end
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
        end
        @(negedge clk);
        req_valid = '0;
        nreset    = 1'b1;
    endtask

    task automatic test_single();
        int n;
        bit found;
        do_reset();
        set_default_data();
        req_x[2*DW +: DW]     = 16'h4000;
        req_y[2*DW +: DW]     = 16'h0000;
        req_angle[2*AW +: AW] = 20'(CORDIC_ANGLE_FULL / 4);
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_grant got=%b want=0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        tests++; if (core_enable !== 1'b1) begin fails++; $display("FAIL single_core_enable got=%b want=1", core_enable); end
        tests++; if (core_x !== 16'h4000 || core_y !== 16'h0000 || core_angle !== 20'h04000) begin
            fails++; $display("FAIL single_core_in got=%h/%h/%h want=4000/0000/04000", core_x, core_y, core_angle); end
        found = 1'b0;
        for (n = 1; n <= 40; n++) begin
            if (rsp_valid !== 4'b0000) begin found = 1'b1; break; end
            @(negedge clk);
            #1;
        end
        tests++; if (!found || n != L + 2) begin fails++; $display("FAIL single_latency got=%0d found=%0d want=%0d", n, found, L + 2); end
        tests++; if (rsp_valid !== 4'b0100 || rsp_id !== 2'd2) begin
            fails++; $display("FAIL single_rsp_id got=%b/%0d want=0100/2", rsp_valid, rsp_id); end
        tests++; if (rsp_x !== 16'hBFFF || rsp_y !== 16'h4000) begin
            fails++; $display("FAIL single_rsp_data got=%h/%h want=bfff/4000", rsp_x, rsp_y); end
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 4'b0000 || busy !== 1'b0 || core_enable !== 1'b0) begin
            fails++; $display("FAIL single_drain got=%b/%b/%b want=0000/0/0", rsp_valid, busy, core_enable); end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        set_default_data();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_valid = '1;
            #1;
            tests++; if (req_ready !== (4'b0001 << (c % 4))) begin
                fails++; $display("FAIL rr_grant[%0d] got=%b want=%b", c, req_ready, 4'b0001 << (c % 4)); end
        end
        @(negedge clk);
        req_valid = '0;
        for (n = 0; n < 40; n++) begin
            #1;
            if (rsp_valid !== 4'b0000) break;
            @(negedge clk);
        end
        tests++; if (n >= 40) begin fails++; $display("FAIL rr_timeout got=no response want=response"); end
        for (int j = 0; j < 8; j++) begin
            tests++; if (rsp_valid !== (4'b0001 << (j % 4)) || rsp_id !== 2'(j % 4) ||
                         rsp_x !== (16'hEFFF - 16'(j % 4)) || rsp_y !== (16'h0200 * 16'(j % 4))) begin
                fails++; $display("FAIL rr_rsp[%0d] got=%b/%0d/%h/%h want=%b/%0d/%h/%h", j, rsp_valid, rsp_id,
                    rsp_x, rsp_y, 4'b0001 << (j % 4), j % 4, 16'hEFFF - 16'(j % 4), 16'h0200 * 16'(j % 4)); end
            @(negedge clk);
            #1;
        end
        tests++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL rr_after got=%b want=0000", rsp_valid); end
    endtask

    task automatic test_pause();
        int nrsp;
        int gaps;
        do_reset();
        set_default_data();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_valid = '1;
            pause     = (c >= 3);
            #1;
            if (c < 3) begin
                tests++; if (req_ready !== (4'b0001 << c)) begin
                    fails++; $display("FAIL pause_pre_grant[%0d] got=%b want=%b", c, req_ready, 4'b0001 << c); end
            end else begin
                tests++; if (req_ready !== 4'b0000 || core_enable !== 1'b1) begin
                    fails++; $display("FAIL pause_hold[%0d] got=%b/%b want=0000/1", c, req_ready, core_enable); end
            end
        end
        @(negedge clk);
        req_valid = '0;
        pause     = 1'b0;
        nrsp = 0;
        gaps = 0;
        for (int n = 0; n < 40 && nrsp < 3; n++) begin
            #1;
            if (rsp_valid !== 4'b0000) begin
                tests++; if (rsp_valid !== (4'b0001 << nrsp)) begin
                    fails++; $display("FAIL pause_rsp[%0d] got=%b want=%b", nrsp, rsp_valid, 4'b0001 << nrsp); end
                nrsp++;
            end
            if (nrsp < 3 && core_enable !== 1'b1) gaps++;
            if (nrsp < 3) @(negedge clk);
        end
        tests++; if (nrsp != 3) begin fails++; $display("FAIL pause_count got=%0d want=3", nrsp); end
        tests++; if (gaps != 0) begin fails++; $display("FAIL pause_enable_gap got=%0d want=0", gaps); end
        tests++; if (core_enable !== 1'b0) begin fails++; $display("FAIL pause_enable_off got=%b want=0", core_enable); end
    endtask

    task automatic test_issue_retire();
        int gaps;
        int n;
        do_reset();
        set_default_data();
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL ir_first got=%b want=0001", req_ready); end
        gaps = 0;
        for (int i = 1; i <= L; i++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (core_enable !== 1'b1) gaps++;
        end
        // Second issue lands in the cycle the first tag leaves the pipeline.
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        tests++; if (req_ready !== 4'b0010 || core_enable !== 1'b1 || gaps != 0) begin
            fails++; $display("FAIL ir_second got=%b/%b gaps=%0d want=0010/1 gaps=0", req_ready, core_enable, gaps); end
        @(negedge clk);
        req_valid = '0;
        #1;
        tests++; if (core_enable !== 1'b1 || rsp_valid !== 4'b0001) begin
            fails++; $display("FAIL ir_overlap got=%b/%b want=1/0001", core_enable, rsp_valid); end
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            #1;
            if (rsp_valid !== 4'b0000) break;
        end
        tests++; if (n != L + 1 || rsp_valid !== 4'b0010 || rsp_id !== 2'd1 || rsp_x !== 16'hEFFE) begin
            fails++; $display("FAIL ir_second_rsp got=%0d/%b/%0d/%h want=%0d/0010/1/effe", n, rsp_valid, rsp_id, rsp_x, L + 1); end
    endtask

    task automatic test_reset_midflight();
        int stray;
        do_reset();
        set_default_data();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = '1;
            #1;
            tests++; if (req_ready !== (4'b0001 << (c % 4))) begin
                fails++; $display("FAIL mid_grant[%0d] got=%b want=%b", c, req_ready, 4'b0001 << (c % 4)); end
        end
        @(negedge clk);
        nreset = 1'b0;
        #1;
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL mid_reset_ready got=%b want=0000", req_ready); end
        @(negedge clk);
        nreset    = 1'b1;
        req_valid = '0;
        stray = 0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (rsp_valid !== 4'b0000 || busy !== 1'b0) stray++;
            @(negedge clk);
        end
        tests++; if (stray != 0) begin fails++; $display("FAIL mid_stray_rsp got=%0d want=0", stray); end
        req_valid = '1;
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_ptr_restart got=%b want=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
    endtask

`ifdef CORDIC_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        @(negedge clk);
        req_valid = 4'b0010;
        repeat (70000) @(negedge clk);
        req_valid = '0;
        #1;
        tests++; if (grant_count[31:16] !== 16'hFFFF) begin
            fails++; $display("FAIL stats_saturate got=%h want=ffff", grant_count[31:16]); end
        @(negedge clk);
        req_valid   = 4'b0010;
        stats_clear = 1'b1;
        @(negedge clk);
        req_valid   = '0;
        stats_clear = 1'b0;
        #1;
        tests++; if (grant_count[31:16] !== 16'h0000) begin
            fails++; $display("FAIL stats_clear got=%h want=0000", grant_count[31:16]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pause();
        test_issue_retire();
        test_reset_midflight();
`ifdef CORDIC_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
